serial_full_adder: RTL and testbench

- Bit-serial N-bit adder built around a single full-adder cell and a carry flop; it is the additive counterpart of the full_subtractor cell.
- Operands are loaded in parallel on a start request, then added LSB-first at one bit per clock; the result is returned in parallel with a done pulse.
- Used as the area-cheap arithmetic unit in the arithmetic block set, and as the reference model for subtract/add round-trip checks (a - b + b == a).

---
 rtl/arith_pkg.sv | 19 +
 rtl/serial_full_adder_fa.sv | 19 +
 rtl/serial_full_adder.sv | 103 ++++++++++
 tb/tb_serial_full_adder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t    : sequencing states used by serial_full_adder
//   MAX_WIDTH  : largest supported operand width
//   cnt_width(): bit counter width needed to count 0..width without wrapping
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_full_adder_fa.sv
// One-bit combinational full-adder cell.
//   a, b : operand bits
//   cin  : carry in
//   sum  : a ^ b ^ cin
//   cout : majority(a, b, cin)
// Port names mirror the full_subtractor cell (a, b, bin/cin) so the two are
// interchangeable in serial datapaths.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop.
// Operands are captured on an accepted start, added LSB-first one bit per
// clock, and the result is presented in parallel with a one-cycle done pulse.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : begin an addition (only honoured in IDLE)
//   a, b  : operands, captured on acceptance
//   cin   : carry in, captured on acceptance
//   busy  : high while bits are being processed
//   done  : one-cycle pulse, sum/cout valid
//   sum   : a + b + cin mod 2^WIDTH, held until the next result
//   cout  : carry out of the MSB, held with sum
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one bit per clock, LSB first
// DONE  | result just latched, done pulse for one cycle
module serial_full_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_sh_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // New sum bit enters at the MSB; written as a shift/or so WIDTH=1 needs no
  // special-case slice.
  assign s_sh_next = (s_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_sh_next;
          // Counter reaches WIDTH on the last bit; CW is sized so it never wraps.
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= s_sh_next;
            cout  <= fa_cout;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
module tb_serial_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  // 4-bit instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  // 1-bit instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

  serial_full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  // Reference ripple subtractor: a - b mod 16, built bit by bit from the
  // full-subtractor equations.
  function automatic logic [3:0] sub4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] d;
    logic       bw;
    bw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = x[i] ^ y[i] ^ bw;
      bw   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw);
    end
    return d;
  endfunction

  // Drivers: start one op, scramble operands after acceptance, wait for done.
  // lat = clocks from the accepting edge to the edge that raises done (-1 on timeout).
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      output logic [7:0] s, output logic co, output int lat, output int bcnt);
    @(posedge clk); #1;
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~av; b8 = ~bv; cin8 = ~cv;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done8) lat = -1;
    s = sum8; co = cout8;
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                      output logic [3:0] s, output logic co, output int lat);
    @(posedge clk); #1;
    start4 = 1'b1; a4 = av; b4 = bv; cin4 = cv;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~av; b4 = ~bv; cin4 = ~cv;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done4) lat = -1;
    s = sum4; co = cout4;
  endtask

  task automatic run1(input logic av, input logic bv, input logic cv,
                      output logic s, output logic co, output int lat);
    @(posedge clk); #1;
    start1 = 1'b1; a1 = av; b1 = bv; cin1 = cv;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done1) lat = -1;
    s = sum1; co = cout1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'h0) $display("FAIL reset8 got=%h want=0", {busy8, done8, sum8, cout8});
    else passed++;
    checks++;
    if ({busy4, done4, sum4, cout4} !== 7'h0) $display("FAIL reset4 got=%h want=0", {busy4, done4, sum4, cout4});
    else passed++;
    checks++;
    if ({busy1, done1, sum1, cout1} !== 4'h0) $display("FAIL reset1 got=%h want=0", {busy1, done1, sum1, cout1});
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] s; logic co; int lat, bc;
    run8(8'h35, 8'h4A, 1'b0, s, co, lat, bc);
    checks++;
    if (lat !== 8) $display("FAIL basic_latency got=%0d want=8", lat); else passed++;
    checks++;
    if (bc !== 8) $display("FAIL basic_busy_cycles got=%0d want=8", bc); else passed++;
    checks++;
    if ({co, s} !== 9'h07F) $display("FAIL basic_35_4A got=%h want=07f", {co, s}); else passed++;
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || sum8 !== 8'h7F) $display("FAIL done_one_cycle got done=%b sum=%h want done=0 sum=7f", done8, sum8);
    else passed++;
    run8(8'hFF, 8'h01, 1'b0, s, co, lat, bc);
    checks++;
    if ({co, s} !== 9'h100 || lat !== 8) $display("FAIL ff_01 got=%h lat=%0d want=100 lat=8", {co, s}, lat); else passed++;
    run8(8'hFF, 8'hFF, 1'b1, s, co, lat, bc);
    checks++;
    if ({co, s} !== 9'h1FF || lat !== 8) $display("FAIL ff_ff_c1 got=%h lat=%0d want=1ff lat=8", {co, s}, lat); else passed++;
    run8(8'h80, 8'h80, 1'b0, s, co, lat, bc);
    checks++;
    if ({co, s} !== 9'h100) $display("FAIL 80_80 got=%h want=100", {co, s}); else passed++;
    run8(8'h00, 8'h00, 1'b1, s, co, lat, bc);
    checks++;
    if ({co, s} !== 9'h001) $display("FAIL 00_00_c1 got=%h want=001", {co, s}); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep4;
    logic [3:0] s; logic co; int lat;
    int bad;
    bad = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          run4(4'(x), 4'(y), 1'(c), s, co, lat);
          checks++;
          if ({co, s} !== 5'(x + y + c) || lat !== 4) begin
            if (bad < 10) $display("FAIL sweep4 a=%0d b=%0d cin=%0d got=%h lat=%0d want=%h lat=4",
                                   x, y, c, {co, s}, lat, 5'(x + y + c));
            bad++;
          end else passed++;
        end
    // a - b + b must give a back
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        run4(sub4(4'(x), 4'(y)), 4'(y), 1'b0, s, co, lat);
        checks++;
        if (s !== 4'(x)) begin
          if (bad < 10) $display("FAIL roundtrip a=%0d b=%0d got=%0d want=%0d", x, y, s, x);
          bad++;
        end else passed++;
      end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int  first_t, second_t, npulse, k;
    logic [7:0] first_s, second_s, hold_s;
    first_t = -1; second_t = -1; npulse = 0; first_s = '0; second_s = '0; hold_s = '0;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    @(posedge clk); #1;          // accepting edge E0
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin a8 = 8'h01; b8 = 8'h02; end
      if (k == 12) hold_s = sum8;
      if (done8) begin
        npulse++;
        if (first_t < 0) begin first_t = k; first_s = sum8; end
        else if (second_t < 0) begin second_t = k; second_s = sum8; end
      end
    end
    start8 = 1'b0;
    checks++;
    if (first_t !== 8 || first_s !== 8'h33) $display("FAIL b2b_first got t=%0d sum=%h want t=8 sum=33", first_t, first_s);
    else passed++;
    checks++;
    if (hold_s !== 8'h33) $display("FAIL b2b_hold got=%h want=33", hold_s); else passed++;
    checks++;
    if (second_t !== 18 || second_s !== 8'h03) $display("FAIL b2b_second got t=%0d sum=%h want t=18 sum=03", second_t, second_s);
    else passed++;
    checks++;
    if (npulse !== 2) $display("FAIL b2b_pulses got=%0d want=2", npulse); else passed++;
    k = 0;
    while ((busy8 || done8) && k < 30) begin @(posedge clk); #1; k++; end
    checks++;
    if (busy8 || done8) $display("FAIL b2b_drain got busy=%b done=%b want 0 0", busy8, done8); else passed++;
  endtask

  task automatic test_abort;
    logic [7:0] s; logic co; int lat, bc, npulse;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0;
    @(posedge clk); #1;          // E0, cnt=0
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end   // cnt=3
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'h0) $display("FAIL abort_async got=%h want=0", {busy8, done8, sum8, cout8});
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    npulse = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) npulse++;
    end
    checks++;
    if (npulse !== 0) $display("FAIL abort_no_done got=%0d want=0", npulse); else passed++;
    run8(8'h10, 8'h20, 1'b0, s, co, lat, bc);
    checks++;
    if ({co, s} !== 9'h030 || lat !== 8) $display("FAIL abort_next got=%h lat=%0d want=030 lat=8", {co, s}, lat);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_width1;
    logic s, co; int lat;
    run1(1'b1, 1'b1, 1'b1, s, co, lat);
    checks++;
    if ({co, s} !== 2'b11 || lat !== 1) $display("FAIL w1_111 got=%b lat=%0d want=11 lat=1", {co, s}, lat);
    else passed++;
    run1(1'b1, 1'b0, 1'b0, s, co, lat);
    checks++;
    if ({co, s} !== 2'b01 || lat !== 1) $display("FAIL w1_100 got=%b lat=%0d want=01 lat=1", {co, s}, lat);
    else passed++;
    run1(1'b0, 1'b1, 1'b1, s, co, lat);
    checks++;
    if ({co, s} !== 2'b10) $display("FAIL w1_011 got=%b want=10", {co, s}); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sweep4;
    test_back_to_back;
    test_abort;
    test_width1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
